// File: rtl/bram_dp_clr.sv
// Dual-port block RAM (A: read/write, B: read-only) with a clear sequencer that fills every word with CLEAR_VALUE.
// Define BRAM_DP_CLR_OUTREG_EN to add one output register stage on both ports (2-cycle read latency).
module bram_dp_clr #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int CLEAR_VALUE = 0,
  parameter int RDW_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  output logic                  busy,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] CLR_WORD = DATA_WIDTH'(CLEAR_VALUE);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    a_acc;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic [DATA_WIDTH-1:0]   a_rdata_q, a_rdata_d;
  logic                    a_rvalid_q, a_rvalid_d;
  logic [DATA_WIDTH-1:0]   b_rdata_q, b_rdata_d;
  logic                    b_rvalid_q, b_rvalid_d;

  assign busy  = (state_q == ST_CLEAR);
  assign a_acc = a_en & ~busy & ~rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clear) begin
          cnt_d = '0;
        end else if (cnt_q == '1) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // One shared write port: the sequencer owns it while busy, port A otherwise.
  always_comb begin
    mem_we    = (busy & ~rst) | (a_acc & a_we);
    mem_waddr = busy ? cnt_q : a_addr;
    mem_wdata = busy ? CLR_WORD : a_wdata;
  end

  always_comb begin
    a_rdata_d  = a_rdata_q;
    a_rvalid_d = 1'b0;
    b_rdata_d  = b_rdata_q;
    b_rvalid_d = 1'b0;
    if (a_acc) begin
      a_rvalid_d = 1'b1;
      a_rdata_d  = (a_we && (RDW_MODE != 0)) ? a_wdata : mem[a_addr];
    end
    if (b_en) begin
      b_rvalid_d = 1'b1;
      b_rdata_d  = mem[b_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      a_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rdata_q  <= '0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_rdata_q  <= a_rdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rdata_q  <= b_rdata_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

`ifdef BRAM_DP_CLR_OUTREG_EN
  logic [DATA_WIDTH-1:0] a_rdata_s_q, a_rdata_s_d;
  logic                  a_rvalid_s_q, a_rvalid_s_d;
  logic [DATA_WIDTH-1:0] b_rdata_s_q, b_rdata_s_d;
  logic                  b_rvalid_s_q, b_rvalid_s_d;

  // Stage is not flushed by clear, so a request accepted just before a clear still completes.
  always_comb begin
    a_rdata_s_d  = a_rdata_q;
    a_rvalid_s_d = a_rvalid_q;
    b_rdata_s_d  = b_rdata_q;
    b_rvalid_s_d = b_rvalid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_s_q  <= '0;
      a_rvalid_s_q <= 1'b0;
      b_rdata_s_q  <= '0;
      b_rvalid_s_q <= 1'b0;
    end else begin
      a_rdata_s_q  <= a_rdata_s_d;
      a_rvalid_s_q <= a_rvalid_s_d;
      b_rdata_s_q  <= b_rdata_s_d;
      b_rvalid_s_q <= b_rvalid_s_d;
    end
  end

  assign a_rdata  = a_rdata_s_q;
  assign a_rvalid = a_rvalid_s_q;
  assign b_rdata  = b_rdata_s_q;
  assign b_rvalid = b_rvalid_s_q;
`else
  assign a_rdata  = a_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rdata  = b_rdata_q;
  assign b_rvalid = b_rvalid_q;
`endif

endmodule

// File: tb/tb_bram_dp_clr.sv
// Directed self-checking bench for bram_dp_clr (ADDR_WIDTH=10, DATA_WIDTH=8, CLEAR_VALUE=0).
module tb_bram_dp_clr;

  localparam int AW     = 10;
  localparam int DW     = 8;
  localparam int DEPTH  = 1 << AW;
  localparam int TB_RDW = 0;
`ifdef BRAM_DP_CLR_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst;
  logic          clear;
  logic          busy;
  logic          a_en;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic [DW-1:0] a_rdata;
  logic          a_rvalid;
  logic          b_en;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_rdata;
  logic          b_rvalid;

  int n_checks = 0;
  int n_fail   = 0;

  bram_dp_clr #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CLEAR_VALUE(0),
    .RDW_MODE   (TB_RDW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .busy    (busy),
    .a_en    (a_en),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_rdata (a_rdata),
    .a_rvalid(a_rvalid),
    .b_en    (b_en),
    .b_addr  (b_addr),
    .b_rdata (b_rdata),
    .b_rvalid(b_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      tick();
    end
  endtask

  task automatic a_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    a_en = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data;
    tick();
    a_en = 1'b0; a_we = 1'b0;
    repeat (LAT) tick();
  endtask

  // ok=0 if rvalid shows up early or is missing at the expected latency.
  task automatic read_a(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic ok);
    a_en = 1'b1; a_we = 1'b0; a_addr = addr;
    tick();
    a_en = 1'b0;
    ok = 1'b1;
    for (int k = 1; k < LAT; k++) begin
      if (a_rvalid) ok = 1'b0;
      tick();
    end
    if (!a_rvalid) ok = 1'b0;
    data = a_rdata;
  endtask

  task automatic read_b(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic ok);
    b_en = 1'b1; b_addr = addr;
    tick();
    b_en = 1'b0;
    ok = 1'b1;
    for (int k = 1; k < LAT; k++) begin
      if (b_rvalid) ok = 1'b0;
      tick();
    end
    if (!b_rvalid) ok = 1'b0;
    data = b_rdata;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    logic          ok;
    int            n;
    int            bad;
    int            nv;

    rst = 1'b1; clear = 1'b0;
    a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_en = 1'b0; b_addr = '0;
    repeat (3) tick();

    check("rst_busy",     32'(busy),     32'd1);
    check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    check("rst_a_rdata",  32'(a_rdata),  32'd0);
    check("rst_b_rdata",  32'(b_rdata),  32'd0);

    // Power-up clear: busy for exactly DEPTH cycles, then every word reads zero.
    rst = 1'b0;
    wait_idle(n);
    check("init_busy_cycles", 32'(n),    32'(DEPTH));
    check("init_busy_low",    32'(busy), 32'd0);
    bad = 0; nv = 0;
    for (int i = 0; i < DEPTH; i++) begin
      read_b(AW'(i), d, ok);
      if (d !== 8'h00) bad++;
      if (!ok) nv++;
    end
    check("init_scan_data",   32'(bad), 32'd0);
    check("init_scan_rvalid", 32'(nv),  32'd0);

    // Write then immediate read on port A.
    check("a_idle_rvalid", 32'(a_rvalid), 32'd0);
    a_en = 1'b1; a_we = 1'b1; a_addr = 10'h005; a_wdata = 8'hA5;
    tick();
    a_we = 1'b0;
    tick();
    a_en = 1'b0;
    repeat (LAT - 1) tick();
    check("a_rd_rvalid", 32'(a_rvalid), 32'd1);
    check("a_rd_data",   32'(a_rdata),  32'hA5);
    tick();
    check("a_rd_rvalid_drop", 32'(a_rvalid), 32'd0);

    // Same-cycle A write / B read of one address.
    a_write(10'h010, 8'h11);
    a_en = 1'b1; a_we = 1'b1; a_addr = 10'h010; a_wdata = 8'h22;
    b_en = 1'b1; b_addr = 10'h010;
    tick();
    a_en = 1'b0; a_we = 1'b0; b_en = 1'b0;
    repeat (LAT - 1) tick();
    check("coll_b_rvalid", 32'(b_rvalid), 32'd1);
    check("coll_b_data",   32'(b_rdata),  32'h11);
    check("coll_a_rvalid", 32'(a_rvalid), 32'd1);
    check("coll_a_data",   32'(a_rdata),  (TB_RDW != 0) ? 32'h22 : 32'h11);
    tick();
    read_a(10'h010, d, ok);
    check("coll_after_ok",   32'(ok), 32'd1);
    check("coll_after_data", 32'(d),  32'h22);

    // Clear with port A writes attempted while busy.
    a_write(10'h020, 8'h01);
    a_write(10'h021, 8'h80);
    a_write(10'h022, 8'h5A);
    a_write(10'h023, 8'hFE);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      a_en = 1'b1; a_we = 1'b1; a_addr = AW'(32 + (i % 4)); a_wdata = 8'h77;
      tick();
      if (a_rvalid) nv++;
    end
    a_en = 1'b0; a_we = 1'b0;
    wait_idle(n);
    check("clr_busy_rest",     32'(n),       32'd1004);
    check("clr_drop_rvalid",   32'(nv),      32'd0);
    check("clr_a_rdata_hold",  32'(a_rdata), (TB_RDW != 0) ? 32'hFE : 32'h00);
    for (int i = 0; i < 4; i++) begin
      read_b(AW'(32 + i), d, ok);
      check("clr_word", {23'd0, ok, d}, 32'h100);
    end
    read_b(10'h010, d, ok);
    check("clr_word_10", {23'd0, ok, d}, 32'h100);

    // Clear restarted at cnt=500.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (500) tick();
    check("restart_busy_mid", 32'(busy), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_idle(n);
    check("restart_busy_cycles", 32'(n), 32'(DEPTH));

    // B against clear write, B during busy, then reset mid-clear.
    a_write(10'h000, 8'h5A);
    a_write(10'h030, 8'h3C);
    read_a(10'h000, d, ok);
    check("pre_rst_a_data", {23'd0, ok, d}, 32'h15A);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    b_en = 1'b1; b_addr = 10'h000;
    tick();
    b_en = 1'b0;
    repeat (LAT - 1) tick();
    check("bclr_rvalid", 32'(b_rvalid), 32'd1);
    check("bclr_old",    32'(b_rdata),  32'h5A);
    read_b(10'h000, d, ok);
    check("bbusy_cleared", {23'd0, ok, d}, 32'h100);
    read_b(10'h030, d, ok);
    check("bbusy_not_yet", {23'd0, ok, d}, 32'h13C);
    repeat (200) tick();
    rst = 1'b1;
    tick();
    tick();
    check("mid_rst_busy",     32'(busy),     32'd1);
    check("mid_rst_a_rdata",  32'(a_rdata),  32'd0);
    check("mid_rst_b_rdata",  32'(b_rdata),  32'd0);
    check("mid_rst_a_rvalid", 32'(a_rvalid), 32'd0);
    check("mid_rst_b_rvalid", 32'(b_rvalid), 32'd0);
    rst = 1'b0;
    wait_idle(n);
    check("mid_rst_busy_cycles", 32'(n), 32'(DEPTH));
    read_b(10'h030, d, ok);
    check("post_rst_b_30", {23'd0, ok, d}, 32'h100);
    read_a(10'h000, d, ok);
    check("post_rst_a_00", {23'd0, ok, d}, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
